// File: rtl/bpf_pkg.sv
// bpf_pkg: band tables, FSM state and band index types for the band-pass filter selector.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Tables are padded to 16 entries so a 4-bit band index addresses them exactly.
// Padding limits saturate high and padding codes select bypass.
package bpf_pkg;

  localparam int BPF_NUM_BANDS = 6;

  // Upper band limit (inclusive) in freq[31:16] units (65.536 kHz).
  localparam int unsigned BAND_LIMIT [16] = '{
    38, 91, 191, 305, 458,
    65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535
  };

  // Parallel relay code per band; index 5 is bypass.
  localparam int unsigned BAND_CODE [16] = '{
    6, 2, 0, 3, 1, 7,
    7, 7, 7, 7, 7, 7, 7, 7, 7, 7
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_SETTLE
  } state_t;

  typedef logic [3:0] band_t;

endpackage

// File: rtl/bpf_ser_shifter.sv
// bpf_ser_shifter: serialises a filter word MSB first on ser_data/ser_clk, then strobes ser_en.
// Latency: 2*CLK_DIV*SER_BITS cycles of shifting plus CLK_DIV cycles of latch after start.
// Backpressure: none; start is a one-cycle pulse, shift_end/latch_end flag the final cycle of each phase.
//
// Ports: clock, reset (sync, active-low), start + word (load request),
//        ser_data/ser_clk/ser_en (registered board pins), shift_end/latch_end (phase-end flags).
module bpf_ser_shifter
  import bpf_pkg::*;
#(
  parameter int SER_BITS = 8,
  parameter int CLK_DIV  = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [SER_BITS-1:0] word,
  output logic                ser_data,
  output logic                ser_clk,
  output logic                ser_en,
  output logic                shift_end,
  output logic                latch_end
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(SER_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SER_BITS - 1);

  logic [SER_BITS-1:0] sreg;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic                shifting;
  logic                latching;
  logic                div_wrap;

  assign div_wrap  = (div_cnt == DIV_LAST);
  // Last cycle of the high phase of the final bit.
  assign shift_end = shifting && ser_clk && div_wrap && (bit_cnt == BIT_LAST);
  assign latch_end = latching && div_wrap;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sreg     <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shifting <= 1'b0;
      latching <= 1'b0;
      ser_data <= 1'b0;
      ser_clk  <= 1'b0;
      ser_en   <= 1'b0;
    end else if (start) begin
      sreg     <= word;
      ser_data <= word[SER_BITS-1];
      ser_clk  <= 1'b0;
      ser_en   <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shifting <= 1'b1;
      latching <= 1'b0;
    end else if (shifting) begin
      if (!div_wrap) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (!ser_clk) begin
          ser_clk <= 1'b1;
        end else begin
          // Falling edge: data moves together with the clock going low,
          // so it is stable for the whole high phase.
          ser_clk <= 1'b0;
          if (bit_cnt == BIT_LAST) begin
            shifting <= 1'b0;
            latching <= 1'b1;
            ser_en   <= 1'b1;
            ser_data <= 1'b0;
          end else begin
            bit_cnt  <= bit_cnt + 1'b1;
            sreg     <= sreg << 1;
            ser_data <= sreg[SER_BITS-2];
          end
        end
      end
    end else if (latching) begin
      if (!div_wrap) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt  <= '0;
        latching <= 1'b0;
        ser_en   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bpf_seq_ctrl.sv
// bpf_seq_ctrl: maps tuned frequency to a band-pass filter band and sequences the relay board.
// Latency: 4 cycles freq -> bpf_code (parallel); busy lasts 1+SETTLE_CYC or 1+2*CLK_DIV*SER_BITS+CLK_DIV+SETTLE_CYC.
// Backpressure: none; ptt high holds off new switches, freq changes during a switch wait for IDLE.
//
// Ports: clock, reset (sync, active-low), freq, ptt, ser_mode in;
//        bpf_code, band_idx, vhf, busy, ser_data/ser_clk/ser_en out (all registered).
// Optional: define BPF_HYST_EN to keep the current band within +/-HYST of its edges.
module bpf_seq_ctrl
  import bpf_pkg::*;
#(
  parameter int FREQ_W     = 32,
  parameter int CODE_W     = 3,
  parameter int NUM_BANDS  = BPF_NUM_BANDS,
  parameter int SER_BITS   = 8,
  parameter int CLK_DIV    = 2,
  parameter int SETTLE_CYC = 16,
  parameter int HYST       = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [FREQ_W-1:0] freq,
  input  logic              ptt,
  input  logic              ser_mode,
  output logic [CODE_W-1:0] bpf_code,
  output logic [3:0]        band_idx,
  output logic              ser_data,
  output logic              ser_clk,
  output logic              ser_en,
  output logic              busy,
  output logic              vhf
);

  localparam int    FT_W      = FREQ_W - 16;
  localparam int    LIM_W     = FT_W + 1;
  localparam int    SC_W      = $clog2(SETTLE_CYC + 1);
  localparam band_t LAST_BAND = band_t'(NUM_BANDS - 1);
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYC - 1);

  logic [FT_W-1:0]     ftop;
  logic [LIM_W-1:0]    ftop_x;
  band_t               raw_band;
  band_t               next_target;
  band_t               target;
  state_t              state;
  logic [SC_W-1:0]     settle_cnt;
  logic                ser_start;
  logic [SER_BITS-1:0] ser_word;
  logic                shift_end;
  logic                latch_end;
  logic                unused_freq_lsb;

  assign unused_freq_lsb = ^freq[15:0];
  // One bit of headroom so limit +/- margin never wraps.
  assign ftop_x = {1'b0, ftop};

  // Smallest band whose upper limit covers ftop; bypass otherwise.
  always_comb begin
    raw_band = LAST_BAND;
    for (int i = NUM_BANDS - 2; i >= 0; i--) begin
      if (ftop_x <= LIM_W'(BAND_LIMIT[band_t'(i)]))
        raw_band = band_t'(i);
    end
  end

`ifdef BPF_HYST_EN
  logic [LIM_W-1:0] lo_lim, hi_lim, lo_bound, hi_bound;
  logic [LIM_W:0]   hi_sum;
  logic             keep;

  always_comb begin
    lo_lim   = LIM_W'(BAND_LIMIT[band_idx - 4'd1]);
    hi_lim   = LIM_W'(BAND_LIMIT[band_idx]);
    hi_sum   = {1'b0, hi_lim} + (LIM_W+1)'(HYST);
    lo_bound = (lo_lim > LIM_W'(HYST)) ? lo_lim - LIM_W'(HYST) : '0;
    hi_bound = hi_sum[LIM_W] ? '1 : hi_sum[LIM_W-1:0];
    // Band 0 has no lower edge and bypass has no upper edge.
    keep = ((band_idx == '0) || (ftop_x > lo_bound)) &&
           ((band_idx == LAST_BAND) || (ftop_x <= hi_bound));
  end

  assign next_target = keep ? band_idx : raw_band;
`else
  localparam int unused_hyst = HYST;
  assign next_target = raw_band;
`endif

  // Reset ftop to all-ones so the pipeline holds bypass until a real
  // frequency has flowed through.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ftop   <= '1;
      target <= LAST_BAND;
    end else begin
      ftop   <= freq[FREQ_W-1:16];
      target <= next_target;
    end
  end

  assign ser_start = (state == ST_LOAD) && ser_mode;
  assign ser_word  = {{(SER_BITS-1){1'b0}}, 1'b1} << target;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      band_idx   <= LAST_BAND;
      bpf_code   <= CODE_W'(BAND_CODE[LAST_BAND]);
      vhf        <= 1'b1;
      busy       <= 1'b0;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if ((target != band_idx) && !ptt) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          band_idx   <= target;
          bpf_code   <= CODE_W'(BAND_CODE[target]);
          vhf        <= (target == LAST_BAND);
          settle_cnt <= '0;
          state      <= ser_mode ? ST_SHIFT : ST_SETTLE;
        end
        ST_SHIFT: begin
          if (shift_end)
            state <= ST_LATCH;
        end
        ST_LATCH: begin
          if (latch_end) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  bpf_ser_shifter #(
    .SER_BITS (SER_BITS),
    .CLK_DIV  (CLK_DIV)
  ) u_shifter (
    .clock     (clock),
    .reset     (reset),
    .start     (ser_start),
    .word      (ser_word),
    .ser_data  (ser_data),
    .ser_clk   (ser_clk),
    .ser_en    (ser_en),
    .shift_end (shift_end),
    .latch_end (latch_end)
  );

endmodule

// File: tb/tb_bpf_seq_ctrl.sv
// tb_bpf_seq_ctrl: directed stimulus with a per-cycle reference model and literal spot checks.
module tb_bpf_seq_ctrl;

  localparam int CD        = 2;
  localparam int SB        = 8;
  localparam int SC        = 16;
  localparam int HY        = 2;
  localparam int SHIFT_CYC = 2 * CD * SB;
  localparam int LEN_PAR   = 1 + SC;
  localparam int LEN_SER   = 1 + SHIFT_CYC + CD + SC;
`ifdef BPF_HYST_EN
  localparam bit HYST_EN = 1'b1;
`else
  localparam bit HYST_EN = 1'b0;
`endif
  localparam int LIM   [5] = '{38, 91, 191, 305, 458};
  localparam int CODES [6] = '{6, 2, 0, 3, 1, 7};

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] freq;
  logic        ptt;
  logic        ser_mode;
  logic [2:0]  bpf_code;
  logic [3:0]  band_idx;
  logic        ser_data, ser_clk, ser_en, busy, vhf;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  bpf_seq_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .freq     (freq),
    .ptt      (ptt),
    .ser_mode (ser_mode),
    .bpf_code (bpf_code),
    .band_idx (band_idx),
    .ser_data (ser_data),
    .ser_clk  (ser_clk),
    .ser_en   (ser_en),
    .busy     (busy),
    .vhf      (vhf)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Band selection from the band table, with optional hysteresis around band b.
  function automatic int classify(input int ft, input int b);
    int raw;
    raw = 5;
    for (int i = 4; i >= 0; i--) if (ft <= LIM[i]) raw = i;
    if (HYST_EN && (b == 0 || ft + HY > LIM[b-1]) && (b == 5 || ft <= LIM[b] + HY))
      return b;
    return raw;
  endfunction

  // Reference model: pipeline of ftop/target, then a switch described by its
  // elapsed cycle count m_t (0 = load cycle) and total busy length.
  int m_f1, m_tgt, m_band, m_t, m_len;
  bit m_act, m_ser;

  always @(posedge clock) begin
    int nt;
    if (!reset) begin
      m_f1 = 65535; m_tgt = 5; m_band = 5; m_act = 0; m_t = 0; m_len = 0; m_ser = 0;
    end else begin
      nt = classify(m_f1, m_band);
      if (m_act) begin
        if (m_t == 0) begin
          m_band = m_tgt;
          m_ser  = ser_mode;
          m_len  = m_ser ? LEN_SER : LEN_PAR;
        end
        m_t++;
        if (m_t >= m_len) m_act = 0;
      end else if (m_tgt != m_band && !ptt) begin
        m_act = 1; m_t = 0; m_len = 1000;
      end
      m_tgt = nt;
      m_f1  = int'(freq[31:16]);
    end
  end

  always @(negedge clock) begin
    int s;
    logic ec, ed, ee;
    bit sh;
    if (chk_en) begin
      ec = 1'b0; ed = 1'b0; ee = 1'b0;
      sh = m_act && m_ser && (m_t >= 1);
      s  = m_t - 1;
      if (sh && s < SHIFT_CYC) begin
        ec = ((s % (2 * CD)) >= CD);
        ed = 1'(((1 << m_band) >> (SB - 1 - s / (2 * CD))) & 1);
      end else if (sh && s < SHIFT_CYC + CD) begin
        ee = 1'b1;
      end
      check("model_bpf_code", 32'(bpf_code), CODES[m_band]);
      check("model_band_idx", 32'(band_idx), m_band);
      check("model_vhf",      32'(vhf),      32'(m_band == 5));
      check("model_busy",     32'(busy),     32'(m_act));
      check("model_ser_clk",  32'(ser_clk),  32'(ec));
      check("model_ser_data", 32'(ser_data), 32'(ed));
      check("model_ser_en",   32'(ser_en),   32'(ee));
    end
  end

  task automatic set_ftop(input int ft);
    freq = (32'(ft) << 16) | 32'h0000_5A5A;
  endtask

  task automatic wait_switch();
    int g;
    repeat (4) @(negedge clock);
    g = 0;
    while (busy && g < 200) begin @(negedge clock); g++; end
    check("wait_idle", 32'(busy), 0);
  endtask

  task automatic wait_busy();
    int g;
    g = 0;
    while (!busy && g < 10) begin @(negedge clock); g++; end
    check("busy_start", 32'(busy), 1);
  endtask

  task automatic count_busy(inout int n);
    int g;
    g = 0;
    while (busy && g < 200) begin
      @(negedge clock);
      if (busy) n++;
      g++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, rises, first_rise, last_rise, en_cyc, viol;
    logic [7:0] word;
    logic prev_clk, prev_data;

    reset = 1'b0; ptt = 1'b0; ser_mode = 1'b0;
    set_ftop(600);
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    check("rst_code", 32'(bpf_code), 7);
    check("rst_band", 32'(band_idx), 5);
    check("rst_vhf",  32'(vhf), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ser",  32'({ser_data, ser_clk, ser_en}), 0);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    check("bypass_no_switch", 32'(busy), 0);

    // 7.1 MHz -> ftop 108, band 2, code 0, exactly 4 cycles.
    freq = 32'd7_100_000;
    repeat (3) @(negedge clock);
    check("t1_code_hold", 32'(bpf_code), 7);
    check("t1_busy_up",   32'(busy), 1);
    @(negedge clock);
    check("t1_code", 32'(bpf_code), 0);
    check("t1_band", 32'(band_idx), 2);
    check("t1_vhf",  32'(vhf), 0);
    n = 2;
    count_busy(n);
    check("t1_busy_len", n, 17);

    // Band edge behaviour around limit 191.
    set_ftop(216); wait_switch();
    check("t2_code_216", 32'(bpf_code), 3);
    set_ftop(190); wait_switch();
    check("t2_band_190", 32'(band_idx), HYST_EN ? 3 : 2);
    set_ftop(189); wait_switch();
    check("t2_band_189", 32'(band_idx), 2);
    check("t2_code_189", 32'(bpf_code), 0);

    // PTT freezes band changes; pending change applies once ptt falls.
    set_ftop(60); wait_switch();
    check("t3_band1", 32'(band_idx), 1);
    ptt = 1'b1;
    set_ftop(400);
    repeat (25) @(negedge clock);
    check("t3_frozen_code", 32'(bpf_code), 2);
    check("t3_frozen_busy", 32'(busy), 0);
    ptt = 1'b0;
    @(negedge clock);
    check("t3_rel_busy", 32'(busy), 1);
    @(negedge clock);
    check("t3_rel_code", 32'(bpf_code), 1);
    wait_switch();

    // Serial switch to band 4.
    set_ftop(100); wait_switch();
    ser_mode = 1'b1;
    set_ftop(400);
    wait_busy();
    n = 1; rises = 0; first_rise = 0; last_rise = 0; en_cyc = 0; viol = 0; word = '0;
    prev_clk = ser_clk; prev_data = ser_data;
    for (int g = 0; g < 200 && busy; g++) begin
      @(negedge clock);
      if (busy) begin
        n++;
        if (ser_clk && !prev_clk) begin
          rises++;
          word = {word[6:0], ser_data};
          if (rises == 1) first_rise = n;
          last_rise = n;
        end
        if (ser_clk && prev_clk && ser_data != prev_data) viol++;
        if (ser_en) en_cyc++;
      end
      prev_clk = ser_clk; prev_data = ser_data;
    end
    check("t4_word",     32'(word), 32'h10);
    check("t4_rises",    rises, 8);
    check("t4_spacing",  last_rise - first_rise, 28);
    check("t4_en_cyc",   en_cyc, 2);
    check("t4_data_hold", viol, 0);
    check("t4_busy_len", n, 51);
    ser_mode = 1'b0;

    // Bypass boundary.
    set_ftop(459); wait_switch();
    check("t5_code_459", 32'(bpf_code), HYST_EN ? 1 : 7);
    check("t5_vhf_459",  32'(vhf), HYST_EN ? 0 : 1);
    set_ftop(458); wait_switch();
    check("t5_code_458", 32'(bpf_code), 1);
    check("t5_band_458", 32'(band_idx), 4);
    check("t5_vhf_458",  32'(vhf), 0);

    // Reset during the third shifted bit.
    ser_mode = 1'b1;
    set_ftop(10);
    wait_busy();
    repeat (10) @(negedge clock);
    check("t6_mid_band", 32'(band_idx), 0);
    reset = 1'b0;
    @(negedge clock);
    check("t6_rst_code", 32'(bpf_code), 7);
    check("t6_rst_band", 32'(band_idx), 5);
    check("t6_rst_vhf",  32'(vhf), 1);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_ser",  32'({ser_data, ser_clk, ser_en}), 0);
    reset = 1'b1;
    ser_mode = 1'b0;
    wait_switch();
    check("t6_new_band", 32'(band_idx), 0);
    check("t6_new_code", 32'(bpf_code), 6);

    repeat (2) @(negedge clock);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
